// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: IF lookup and EX resolution signals of the branch predictor.
interface branch_predict_unit_if #(
    parameter int NCOND = 2,
    parameter int PC_W  = 32
);
    logic [PC_W-1:0]  fetch_pc;
    logic             pred_taken;
    logic             res_valid;
    logic [PC_W-1:0]  res_pc;
    logic [NCOND-1:0] res_cond;
    logic             res_pred;
    logic             taken;
    logic             flush;
    logic             flush_dir;
    logic [31:0]      stat_branches;
    logic [31:0]      stat_mispred;
    modport master (
        output fetch_pc, res_valid, res_pc, res_cond, res_pred,
        input  pred_taken, taken, flush, flush_dir, stat_branches, stat_mispred
    );
    modport slave (
        input  fetch_pc, res_valid, res_pc, res_cond, res_pred,
        output pred_taken, taken, flush, flush_dir, stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: 2-bit saturating-counter BHT with taken OR-reduction and registered mispredict flush.
// Define BPU_STATS_EN to build the saturating resolved/mispredict statistics counters.
module branch_predict_unit #(
    parameter int NCOND = 2,
    parameter int IDX_W = 6,
    parameter int PC_W  = 32
) (
    input logic clk,
    input logic rst,
    branch_predict_unit_if.slave bus
);
    localparam int N = 1 << IDX_W;
    logic [1:0]       bht_q [N];
    logic [1:0]       bht_d [N];
    logic [1:0]       cur;
    logic [PC_W-1:0]  fpc, rpc;
    logic [IDX_W-1:0] f_idx, r_idx;
    logic [NCOND-1:0] cond;
    logic             mispred, flush_q, flush_d, dir_q, dir_d;
    logic             unused_pc_bits;
    assign fpc            = bus.fetch_pc;
    assign rpc            = bus.res_pc;
    assign unused_pc_bits = ^{fpc, rpc};
    assign f_idx          = fpc[IDX_W+1:2];
    assign r_idx          = rpc[IDX_W+1:2];
    assign cond           = bus.res_cond;
    assign bus.taken      = |cond;
    // Raw array read: a same-cycle update to this index is not bypassed
    assign bus.pred_taken = bht_q[f_idx][1];
    assign mispred        = bus.res_valid && (bus.taken != bus.res_pred);
    assign bus.flush      = flush_q;
    assign bus.flush_dir  = dir_q;
    always_comb begin
        bht_d = bht_q;
        cur   = bht_q[r_idx];
        if (bus.res_valid)
            bht_d[r_idx] = bus.taken ? ((cur == 2'b11) ? cur : cur + 2'd1)
                                     : ((cur == 2'b00) ? cur : cur - 2'd1);
        flush_d = mispred;
        dir_d   = mispred ? bus.taken : dir_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) bht_q[i] <= 2'b01;
            flush_q <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            bht_q   <= bht_d;
            flush_q <= flush_d;
            dir_q   <= dir_d;
        end
    end
`ifdef BPU_STATS_EN
    logic [31:0] br_q, br_d, mp_q, mp_d;
    always_comb begin
        br_d = (bus.res_valid && br_q != '1) ? br_q + 32'd1 : br_q;
        mp_d = (mispred && mp_q != '1) ? mp_q + 32'd1 : mp_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            br_q <= '0;
            mp_q <= '0;
        end else begin
            br_q <= br_d;
            mp_q <= mp_d;
        end
    end
    assign bus.stat_branches = br_q;
    assign bus.stat_mispred  = mp_q;
`else
    assign bus.stat_branches = '0;
    assign bus.stat_mispred  = '0;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: scoreboard bench for branch_predict_unit; flush expectations queue per cycle.
module tb_branch_predict_unit;
    localparam int NCOND = 2;
    localparam int IDX_W = 6;
    localparam int PC_W  = 32;
`ifdef BPU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    typedef struct packed {logic fl; logic dir;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    branch_predict_unit_if #(.NCOND(NCOND), .PC_W(PC_W)) bus ();
    branch_predict_unit #(.NCOND(NCOND), .IDX_W(IDX_W), .PC_W(PC_W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    exp_t       exp_q[$];
    logic [1:0] mbht [64];
    logic       mdir;
    int         mbr, mmp;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [5:0] idx(input logic [31:0] pc);
        return pc[7:2];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mbht[i] = 2'b01;
        mdir = 1'b0;
        mbr  = 0;
        mmp  = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.res_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive_res(input logic [31:0] pc, input logic [1:0] c, input logic pred);
        logic t, m;
        logic [1:0] e;
        t = |c;
        m = (t != pred);
        e = mbht[idx(pc)];
        bus.res_valid = 1'b1;
        bus.res_pc    = pc;
        bus.res_cond  = c;
        bus.res_pred  = pred;
        if (m) mdir = t;
        exp_q.push_back({m, mdir});
        if (t && e != 2'b11) e = e + 2'd1;
        else if (!t && e != 2'b00) e = e - 2'd1;
        mbht[idx(pc)] = e;
        mbr++;
        if (m) mmp++;
    endtask

    task automatic drive_idle();
        bus.res_valid = 1'b0;
        exp_q.push_back({1'b0, mdir});
    endtask

    task automatic test_reset();
        do_reset();
        bus.fetch_pc = 32'h0040_0000;
        #1;
        checks++;
        if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b want 0", bus.pred_taken); end
        checks++;
        if ({bus.flush, bus.flush_dir} !== 2'b00) begin errors++; $display("FAIL reset_flush: got %b%b want 00", bus.flush, bus.flush_dir); end
        checks++;
        if (bus.stat_branches !== 32'd0 || bus.stat_mispred !== 32'd0) begin
            errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", bus.stat_branches, bus.stat_mispred);
        end
        for (int i = 0; i < 64; i++) begin
            bus.fetch_pc = 32'h0040_0000 + 32'(i * 4);
            #1;
            checks++;
            if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_entry%0d: got %b want 0", i, bus.pred_taken); end
        end
    endtask

    task automatic test_mispredict();
        exp_t e;
        bus.fetch_pc = 32'h0040_0010;
        drive_res(32'h0040_0010, 2'b01, 1'b0);
        #1;
        checks++;
        if (bus.taken !== 1'b1) begin errors++; $display("FAIL mp_taken: got %b want 1", bus.taken); end
        checks++;
        if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL mp_pred_before: got %b want 0", bus.pred_taken); end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({bus.flush, bus.flush_dir} !== e) begin errors++; $display("FAIL mp_flush: got %b%b want %b", bus.flush, bus.flush_dir, e); end
        checks++;
        if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL mp_pred_after: got %b want 1", bus.pred_taken); end
        drive_idle();
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({bus.flush, bus.flush_dir} !== e) begin errors++; $display("FAIL mp_idle: got %b%b want %b", bus.flush, bus.flush_dir, e); end
    endtask

    task automatic test_saturate();
        exp_t e;
        bus.fetch_pc = 32'h0040_0020;
        for (int i = 0; i < 5; i++) begin
            drive_res(32'h0040_0020, (i < 4) ? 2'b01 : 2'b00, mbht[8][1]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({bus.flush, bus.flush_dir} !== e) begin errors++; $display("FAIL sat_flush%0d: got %b%b want %b", i, bus.flush, bus.flush_dir, e); end
            checks++;
            if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL sat_pred%0d: got %b want 1", i, bus.pred_taken); end
        end
        drive_idle();
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({bus.flush, bus.flush_dir} !== e) begin errors++; $display("FAIL sat_idle: got %b%b want %b", bus.flush, bus.flush_dir, e); end
    endtask

    task automatic test_alias();
        exp_t e;
        bus.fetch_pc = 32'h0040_0003;
        drive_res(32'h0040_0100, 2'b10, 1'b0);
        #1;
        checks++;
        if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL alias_same_cycle: got %b want 0", bus.pred_taken); end
        @(posedge clk); #1;
        bus.res_valid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({bus.flush, bus.flush_dir} !== e) begin errors++; $display("FAIL alias_flush: got %b%b want %b", bus.flush, bus.flush_dir, e); end
        checks++;
        if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL alias_next: got %b want 1", bus.pred_taken); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] pc;
        logic [1:0] c;
        for (int i = 0; i < 10; i++) begin
            pc = $urandom & 32'hFFFF_FFFC;
            c  = 2'($urandom_range(0, 3));
            bus.fetch_pc = pc;
            drive_res(pc, c, (i < 6) ? ~|c : |c);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({bus.flush, bus.flush_dir} !== e) begin errors++; $display("FAIL b2b_flush%0d: got %b%b want %b", i, bus.flush, bus.flush_dir, e); end
            checks++;
            if (bus.pred_taken !== mbht[idx(pc)][1]) begin errors++; $display("FAIL b2b_pred%0d: got %b want %b", i, bus.pred_taken, mbht[idx(pc)][1]); end
        end
        drive_idle();
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({bus.flush, bus.flush_dir} !== e) begin errors++; $display("FAIL b2b_idle: got %b%b want %b", bus.flush, bus.flush_dir, e); end
    endtask

    task automatic test_reset_priority();
        exp_t e;
        bus.fetch_pc = 32'h0040_0040;
        drive_res(32'h0040_0040, 2'b01, 1'b1);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({bus.flush, bus.flush_dir} !== e) begin errors++; $display("FAIL rp_pre_flush: got %b%b want %b", bus.flush, bus.flush_dir, e); end
        rst = 1'b1;
        bus.res_valid = 1'b1;
        bus.res_cond  = 2'b01;
        bus.res_pred  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.res_valid = 1'b0;
        model_reset();
        checks++;
        if (bus.flush !== 1'b0) begin errors++; $display("FAIL rp_flush: got %b want 0", bus.flush); end
        checks++;
        if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL rp_entry: got %b want 0", bus.pred_taken); end
        checks++;
        if (bus.stat_branches !== 32'd0) begin errors++; $display("FAIL rp_stats: got %0d want 0", bus.stat_branches); end
        drive_idle();
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({bus.flush, bus.flush_dir} !== e) begin errors++; $display("FAIL rp_idle: got %b%b want %b", bus.flush, bus.flush_dir, e); end
    endtask

    task automatic test_stats();
        exp_t e;
        logic [1:0] c;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            c = (i % 2 == 1) ? 2'b10 : 2'b00;
            drive_res(32'h0040_0000 + 32'(i * 4), c, (i == 2 || i == 5 || i == 7) ? ~|c : |c);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({bus.flush, bus.flush_dir} !== e) begin errors++; $display("FAIL st_flush%0d: got %b%b want %b", i, bus.flush, bus.flush_dir, e); end
        end
        bus.res_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.stat_branches !== (STATS ? 32'd10 : 32'd0)) begin
            errors++; $display("FAIL stat_branches: got %0d want %0d", bus.stat_branches, STATS ? 10 : 0);
        end
        checks++;
        if (bus.stat_mispred !== (STATS ? 32'(mmp) : 32'd0)) begin
            errors++; $display("FAIL stat_mispred: got %0d want %0d", bus.stat_mispred, STATS ? mmp : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.fetch_pc  = '0;
        bus.res_valid = 1'b0;
        bus.res_pc    = '0;
        bus.res_cond  = '0;
        bus.res_pred  = 1'b0;
        test_reset();
        test_mispredict();
        test_saturate();
        test_alias();
        test_back_to_back();
        test_reset_priority();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction unit for the pipelined datapath. It generalises the single-cycle taken-OR: any number of branch-condition flags are OR-reduced into one actual-taken decision. Each resolved branch trains a table of 2-bit saturating counters that predicts direction at fetch, and the unit raises a registered flush/redirect pulse on misprediction. It sits between IF (prediction lookup) and EX (resolution).

## Interface
- NCOND, 2, number of branch-condition sources (beq, bne, …); ≥1
- IDX_W, 6, BHT index width; table holds 2^IDX_W entries
- PC_W, 32, program-counter width; must satisfy PC_W ≥ IDX_W+2

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_pc  in  PC_W  PC of instruction in IF
- pred_taken  out  1  predicted direction for fetch_pc (combinational)
- res_valid  in  1  EX is resolving a branch this cycle
- res_pc  in  PC_W  PC of the resolving branch
- res_cond  in  NCOND  per-condition taken flags from EX
- res_pred  in  1  prediction originally issued for this branch (piped from IF)
- taken  out  1  OR-reduction of res_cond (combinational, independent of res_valid)
- flush  out  1  registered one-cycle mispredict pulse
- flush_dir  out  1  registered actual direction accompanying flush (1: redirect to target, 0: to res_pc+4)
- stat_branches  out  32  resolved-branch count (see Configuration)
- stat_mispred  out  32  mispredict count (see Configuration)

## Operation
- Table: 2^IDX_W entries × 2 bits; encodings 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Index: pc[IDX_W+1:2] for both lookup and update; bits [1:0] and above IDX_W+1 ignored (aliasing permitted).
- pred_taken = bit 1 of entry[fetch_pc index]; asynchronous read of the register array.
- taken = |res_cond.
- On res_valid: entry[res_pc index] increments if taken (saturate at 11), decrements if not (saturate at 00).
- Mispredict = res_valid && (taken != res_pred); next cycle flush=1, flush_dir=taken; otherwise flush=0, flush_dir holds its previous value.
- res_valid=0: no table update, flush=0 next cycle.
- Reset values: every entry 01, flush 0, flush_dir 0, stat_branches 0, stat_mispred 0. Reset wins over a concurrent res_valid; no update and no flush are produced from that cycle.

## Timing
- pred_taken, taken: zero-cycle combinational.
- Table update visible on pred_taken from the cycle after res_valid.
- Same-index read and write in one cycle: pred_taken returns the pre-update value; no bypass.
- flush: latency 1 from the res_valid cycle, width exactly 1 cycle per mispredict. Back-to-back mispredicts give consecutive flush cycles.
- No handshake/backpressure; the producer guarantees at most one resolution per cycle.

## Configuration
- BPU_STATS_EN defined: stat_branches increments on every res_valid, and stat_mispred increments on every mispredict. Both are 32-bit, saturate at 0xFFFFFFFF, are updated on the same edge as the table, and are cleared by rst.
- BPU_STATS_EN undefined: no counter registers are built, and stat_branches and stat_mispred are tied to 0.

## Test plan
- Reset, then fetch_pc=0x00400000 → pred_taken=0; every sampled index returns 0; flush=0.
- res_valid=1 with res_pc=0x00400010, res_cond=2'b01, res_pred=0 → taken=1; next cycle flush=1, flush_dir=1; entry 4 becomes 10; fetch_pc=0x00400010 gives pred_taken=1.
- Four consecutive taken resolutions at the same PC, then one not-taken → counter 11 then 10; pred_taken stays 1; flush only on the cycles where res_pred disagrees.
- rst and res_valid together with a mispredict → next cycle flush=0; entry remains 01.
- fetch_pc and res_pc aliasing to the same index in the same cycle, entry=01, taken=1 → pred_taken=0 that cycle and 1 the following cycle.
- With BPU_STATS_EN: 10 resolutions, 3 of them mispredicted → stat_branches=10, stat_mispred=3. Without the macro, both outputs read 0.
